// File: rtl/decode_redirect_controller.sv
// Decode-to-rename pipeline register with front-end redirect sequencing:
// oldest redirecting lane wins, younger lanes squash, then a flush pulse and refill window.

module decode_redirect_lane (
  input  logic i_valid,
  input  logic i_redirect,
  input  logic i_older_hit,
  output logic o_keep,
  output logic o_win,
  output logic o_hit
);
  // A lane survives unless an older lane already claimed the redirect.
  assign o_keep = i_valid & ~i_older_hit;
  assign o_win  = i_valid & i_redirect & ~i_older_hit;
  assign o_hit  = i_older_hit | (i_valid & i_redirect);
endmodule

module decode_redirect_controller #(
  parameter int DECODE_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int REFILL_WAIT  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DECODE_WIDTH-1:0]            decodeValid,
  input  logic [DECODE_WIDTH-1:0]            decodeRedirect,
  input  logic [DECODE_WIDTH*ADDR_WIDTH-1:0] decodeRedirectPC,
  input  logic                               backendRecover,
  input  logic                               renameStall,
  output logic [DECODE_WIDTH-1:0]            outValid,
  output logic                               nextFlush,
  output logic [ADDR_WIDTH-1:0]              nextRecoveredPC,
  output logic                               busy
);
  localparam int CNT_W = (REFILL_WAIT > 1) ? $clog2(REFILL_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] RW_C = CNT_W'(REFILL_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SQUASH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DECODE_WIDTH-1:0] r_outValid, w_outValid_nxt;
  logic                    r_flush, w_flush_nxt;
  logic [ADDR_WIDTH-1:0]   r_pc, w_pc_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;

  logic [DECODE_WIDTH:0]   w_chain;
  logic [DECODE_WIDTH-1:0] w_keep, w_win;
  logic [ADDR_WIDTH-1:0]   w_win_pc;
  logic                    w_any;

  assign w_chain[0] = 1'b0;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    decode_redirect_lane u_lane (
      .i_valid    (decodeValid[g]),
      .i_redirect (decodeRedirect[g]),
      .i_older_hit(w_chain[g]),
      .o_keep     (w_keep[g]),
      .o_win      (w_win[g]),
      .o_hit      (w_chain[g+1])
    );
  end

  assign w_any = w_chain[DECODE_WIDTH];

  // w_win is one-hot or zero, so an OR-reduction acts as the PC mux.
  always_comb begin
    w_win_pc = '0;
    for (int i = 0; i < DECODE_WIDTH; i++)
      if (w_win[i]) w_win_pc = w_win_pc | decodeRedirectPC[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_outValid <= '0;
      r_flush    <= 1'b0;
      r_pc       <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_outValid <= w_outValid_nxt;
      r_flush    <= w_flush_nxt;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_outValid_nxt = r_outValid;
    w_flush_nxt    = 1'b0;
    w_pc_nxt       = r_pc;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (backendRecover) begin
          w_outValid_nxt = '0;
        end else if (renameStall) begin
          w_outValid_nxt = r_outValid;
        end else if (w_any) begin
          w_outValid_nxt = w_keep;
          w_flush_nxt    = 1'b1;
          w_pc_nxt       = w_win_pc;
          w_state_nxt    = S_FLUSH;
        end else begin
          w_outValid_nxt = decodeValid;
        end
      end
      S_FLUSH: begin
        w_outValid_nxt = '0;
        if (backendRecover || REFILL_WAIT == 0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_SQUASH;
          w_cnt_nxt   = RW_C;
        end
      end
      S_SQUASH: begin
        // Refill window counts down even while rename is stalled.
        w_outValid_nxt = '0;
        if (backendRecover) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_outValid_nxt = '0;
        w_cnt_nxt      = '0;
      end
    endcase
  end

  assign outValid        = r_outValid;
  assign nextFlush       = r_flush;
  assign nextRecoveredPC = r_pc;
  assign busy            = (r_state != S_IDLE);
endmodule
